// File: rtl/cntr_ctrl_pkg.sv
// cntr_ctrl_pkg: shared state encoding and default sizing for the run controller
package cntr_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} ctrl_state_e;
  localparam int DEF_PRESCALE = 4;
  localparam int DEF_MAX_LAPS = 10;
  localparam int DEF_LAP_W = 4;
  typedef struct packed {
    logic [$clog2(DEF_PRESCALE)-1:0] psc;
    logic [DEF_LAP_W-1:0] laps;
    ctrl_state_e st;
  } ctrl_regs_t;
endpackage

// File: rtl/rise_edge_det.sv
// rise_edge_det: one-cycle rising-edge flag from a level, history reg reset to RST_VAL
module rise_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_lvl,
  output logic o_edge
);
  logic prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) prev <= RST_VAL;
    else prev <= i_lvl;
  assign o_edge = i_lvl & ~prev;
endmodule

// File: rtl/cntr_run_ctrl.sv
// cntr_run_ctrl: start/stop/clear run controller producing prescaled enable ticks and counting laps
module cntr_run_ctrl
  import cntr_ctrl_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int MAX_LAPS = DEF_MAX_LAPS,
  parameter int LAP_W = DEF_LAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clear,
  input  logic             i_ovf,
  output logic             o_enb,
  output logic             o_clr,
  output logic [LAP_W-1:0] o_laps,
  output logic             o_done,
  output logic [1:0]       o_state
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PSC_TOP = PW'(PRESCALE - 1);
  localparam logic [LAP_W-1:0] LAP_LAST = LAP_W'(MAX_LAPS - 1);
  localparam logic [LAP_W-1:0] LAP_MAX = LAP_W'(MAX_LAPS);
  typedef struct packed {
    logic [PW-1:0] psc;
    logic [LAP_W-1:0] laps;
    ctrl_state_e st;
  } regs_t;
  regs_t q;
  logic start_e, stop_e, clear_e, ovf_e, lap, fin, wrap;
  // Button histories reset high so a button held through reset release is not an edge.
  rise_edge_det #(.RST_VAL(1'b1)) u_start (.clk(clk), .rst(rst), .i_lvl(i_start), .o_edge(start_e));
  rise_edge_det #(.RST_VAL(1'b1)) u_stop  (.clk(clk), .rst(rst), .i_lvl(i_stop),  .o_edge(stop_e));
  rise_edge_det #(.RST_VAL(1'b1)) u_clear (.clk(clk), .rst(rst), .i_lvl(i_clear), .o_edge(clear_e));
  rise_edge_det #(.RST_VAL(1'b0)) u_ovf   (.clk(clk), .rst(rst), .i_lvl(i_ovf),   .o_edge(ovf_e));
  assign lap = ovf_e & (q.st == RUN || q.st == PAUSE);
  assign fin = lap & (q.laps == LAP_LAST);
  assign wrap = q.psc == PSC_TOP;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '{psc: '0, laps: '0, st: IDLE};
      o_enb <= 1'b0;
      o_clr <= 1'b0;
    end else begin
      o_clr <= clear_e;
      o_enb <= 1'b0;
      if (clear_e) q <= '{psc: '0, laps: '0, st: IDLE};
      else if (fin) begin
        q.laps <= LAP_MAX;
        q.st <= DONE;
      end else begin
        if (lap) q.laps <= q.laps + 1'b1;
        case (q.st)
          IDLE: if (start_e) begin
            q.st <= RUN;
            q.psc <= '0;
          end
          RUN: if (stop_e) q.st <= PAUSE;
          else begin
            q.psc <= wrap ? '0 : q.psc + 1'b1;
            o_enb <= wrap;
          end
          PAUSE: if (start_e && !stop_e) q.st <= RUN;
          default: ;
        endcase
      end
    end
  assign o_laps = q.laps;
  assign o_state = q.st;
  assign o_done = q.st == DONE;
endmodule

// File: tb/tb_cntr_run_ctrl.sv
// tb_cntr_run_ctrl: directed scenarios plus randomized run against a cycle-level reference model
module tb_cntr_run_ctrl;
  localparam int PS = 4;
  localparam int MAXL = 3;
  logic clk = 1'b0, rst = 1'b0;
  logic i_start = 1'b0, i_stop = 1'b0, i_clear = 1'b0, i_ovf = 1'b0;
  logic o_enb, o_clr, o_done;
  logic [3:0] o_laps;
  logic [1:0] o_state;
  int passed = 0, total = 0;
  int bad;
  logic [8:0] exp_v;
  cntr_run_ctrl #(.PRESCALE(PS), .MAX_LAPS(MAXL), .LAP_W(4)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_clear(i_clear),
    .i_ovf(i_ovf), .o_enb(o_enb), .o_clr(o_clr), .o_laps(o_laps), .o_done(o_done),
    .o_state(o_state)
  );
  always #5 clk = ~clk;
  // Reference model: state as plain ints (0 idle, 1 run, 2 pause, 3 done), phase counts run cycles mod PS
  int m_state, m_phase, m_laps;
  bit m_enb, m_clr, p_start, p_stop, p_clear, p_ovf, es, ep, ec, eo, act;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = 0; m_phase = 0; m_laps = 0; m_enb = 0; m_clr = 0;
      p_start = 1; p_stop = 1; p_clear = 1; p_ovf = 0;
    end else begin
      es = i_start && !p_start; ep = i_stop && !p_stop;
      ec = i_clear && !p_clear; eo = i_ovf && !p_ovf;
      p_start = i_start; p_stop = i_stop; p_clear = i_clear; p_ovf = i_ovf;
      m_clr = ec; m_enb = 0;
      act = (m_state == 1 || m_state == 2) && eo;
      if (ec) begin
        m_state = 0; m_phase = 0; m_laps = 0;
      end else if (act && m_laps + 1 == MAXL) begin
        m_laps = MAXL; m_state = 3;
      end else begin
        if (act) m_laps++;
        if (m_state == 0 && es) begin
          m_state = 1; m_phase = 0;
        end else if (m_state == 1 && ep) m_state = 2;
        else if (m_state == 1) begin
          m_phase = (m_phase + 1) % PS;
          m_enb = (m_phase == 0);
        end else if (m_state == 2 && es && !ep) m_state = 1;
      end
    end
  end
  task automatic test_reset;
    rst = 1'b0; i_start = 1'b1; i_stop = 1'b0; i_clear = 1'b0; i_ovf = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({o_state, o_enb, o_clr, o_laps, o_done} !== 9'd0) $display("FAIL reset_outputs got=%b exp=0", {o_state, o_enb, o_clr, o_laps, o_done}); else passed++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({o_state, o_enb, o_laps} !== 7'd0) $display("FAIL reset_held_start state=%0d enb=%0d laps=%0d exp=0,0,0", o_state, o_enb, o_laps); else passed++;
    i_start = 1'b0;
    @(negedge clk);
    total++; if (o_state !== 2'd0) $display("FAIL reset_release_start state=%0d exp=0", o_state); else passed++;
  endtask
  task automatic test_tick;
    i_start = 1'b1; @(negedge clk); i_start = 1'b0;
    total++; if (o_state !== 2'd1 || o_enb !== 1'b0) $display("FAIL tick_run_entry state=%0d enb=%0d exp=1,0", o_state, o_enb); else passed++;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++; if (o_enb !== (k % PS == 0)) $display("FAIL tick_cycle_%0d enb=%0d exp=%0d", k, o_enb, (k % PS == 0)); else passed++;
    end
  endtask
  task automatic test_pause_resume;
    repeat (2) @(negedge clk);
    i_stop = 1'b1; @(negedge clk); i_stop = 1'b0;
    total++; if (o_state !== 2'd2 || o_enb !== 1'b0) $display("FAIL pause_entry state=%0d enb=%0d exp=2,0", o_state, o_enb); else passed++;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_enb !== 1'b0 || o_state !== 2'd2) bad++;
    end
    total++; if (bad != 0) $display("FAIL pause_hold bad_cycles=%0d exp=0", bad); else passed++;
    i_start = 1'b1; @(negedge clk); i_start = 1'b0;
    total++; if (o_state !== 2'd1 || o_enb !== 1'b0) $display("FAIL resume_entry state=%0d enb=%0d exp=1,0", o_state, o_enb); else passed++;
    @(negedge clk);
    total++; if (o_enb !== 1'b0) $display("FAIL resume_plus1 enb=%0d exp=0", o_enb); else passed++;
    @(negedge clk);
    total++; if (o_enb !== 1'b1) $display("FAIL resume_plus2 enb=%0d exp=1", o_enb); else passed++;
    @(negedge clk);
    total++; if (o_enb !== 1'b0) $display("FAIL resume_plus3 enb=%0d exp=0", o_enb); else passed++;
  endtask
  task automatic test_laps_done;
    for (int l = 1; l <= MAXL; l++) begin
      i_ovf = 1'b1; @(negedge clk);
      total++; if (o_laps !== 4'(l) || o_state !== (l == MAXL ? 2'd3 : 2'd1) || o_done !== (l == MAXL))
        $display("FAIL lap_%0d laps=%0d state=%0d done=%0d exp=%0d,%0d,%0d", l, o_laps, o_state, o_done, l, (l == MAXL ? 3 : 1), (l == MAXL)); else passed++;
      if (l < MAXL) begin
        repeat (3) @(negedge clk); i_ovf = 1'b0;
        repeat (32) @(negedge clk);
      end
    end
    bad = 0;
    for (int n = 0; n < 55; n++) begin
      i_ovf = (n < 3 || (n >= 30 && n < 34));
      i_start = (n == 10);
      i_stop = (n == 20);
      @(negedge clk);
      if (o_enb !== 1'b0 || o_state !== 2'd3 || o_laps !== 4'(MAXL) || o_done !== 1'b1) bad++;
    end
    i_ovf = 1'b0;
    total++; if (bad != 0) $display("FAIL done_hold bad_cycles=%0d exp=0", bad); else passed++;
  endtask
  task automatic test_clear_done;
    i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;
    total++; if ({o_clr, o_state, o_laps, o_done} !== 8'b1_00_0000_0) $display("FAIL clear_done clr=%0d state=%0d laps=%0d done=%0d exp=1,0,0,0", o_clr, o_state, o_laps, o_done); else passed++;
    @(negedge clk);
    total++; if (o_clr !== 1'b0) $display("FAIL clear_one_cycle clr=%0d exp=0", o_clr); else passed++;
  endtask
  task automatic test_simultaneous;
    i_start = 1'b1; @(negedge clk); i_start = 1'b0; @(negedge clk);
    i_stop = 1'b1; @(negedge clk); i_stop = 1'b0;
    total++; if (o_state !== 2'd2) $display("FAIL sim_pause state=%0d exp=2", o_state); else passed++;
    @(negedge clk);
    i_start = 1'b1; i_stop = 1'b1; @(negedge clk); i_start = 1'b0; i_stop = 1'b0;
    total++; if (o_state !== 2'd2 || o_enb !== 1'b0) $display("FAIL start_stop_same state=%0d enb=%0d exp=2,0", o_state, o_enb); else passed++;
    i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;
    total++; if (o_state !== 2'd0 || o_clr !== 1'b1) $display("FAIL clear_pause state=%0d clr=%0d exp=0,1", o_state, o_clr); else passed++;
    @(negedge clk);
    i_clear = 1'b1; i_start = 1'b1; @(negedge clk); i_clear = 1'b0; i_start = 1'b0;
    total++; if (o_state !== 2'd0 || o_clr !== 1'b1) $display("FAIL clear_start_same state=%0d clr=%0d exp=0,1", o_state, o_clr); else passed++;
    @(negedge clk);
    total++; if (o_state !== 2'd0 || o_clr !== 1'b0) $display("FAIL clear_start_after state=%0d clr=%0d exp=0,0", o_state, o_clr); else passed++;
  endtask
  task automatic test_async_reset;
    i_start = 1'b1; @(negedge clk); i_start = 1'b0;
    i_ovf = 1'b1; @(negedge clk);
    total++; if (o_laps !== 4'd1 || o_state !== 2'd1) $display("FAIL pre_reset laps=%0d state=%0d exp=1,1", o_laps, o_state); else passed++;
    repeat (3) @(negedge clk); i_ovf = 1'b0; @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if ({o_state, o_enb, o_clr, o_laps, o_done} !== 9'd0) $display("FAIL async_reset got=%b exp=0", {o_state, o_enb, o_clr, o_laps, o_done}); else passed++;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (o_state !== 2'd0 || o_clr !== 1'b0) $display("FAIL post_reset state=%0d clr=%0d exp=0,0", o_state, o_clr); else passed++;
  endtask
  task automatic test_random;
    rst = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_clear = 1'b0; i_ovf = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (800) begin
      if ($urandom_range(3) == 0) i_start = ~i_start;
      if ($urandom_range(5) == 0) i_stop = ~i_stop;
      i_clear = ($urandom_range(40) == 0);
      if ($urandom_range(7) == 0) i_ovf = ~i_ovf;
      @(negedge clk);
      exp_v = {m_state[1:0], m_enb, m_clr, m_laps[3:0], (m_state == 3)};
      total++; if ({o_state, o_enb, o_clr, o_laps, o_done} !== exp_v) $display("FAIL random_cycle t=%0t got=%b exp=%b", $time, {o_state, o_enb, o_clr, o_laps, o_done}, exp_v); else passed++;
    end
  endtask
  initial begin
    test_reset;
    test_tick;
    test_pause_resume;
    test_laps_done;
    test_clear_done;
    test_simultaneous;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cntr_run_ctrl.md
Name: cntr_run_ctrl

Overview:
Run/pause/clear controller that sits directly upstream of the mod-n overflow counter.
- Turns start/stop/clear button levels into a prescaled one-cycle enable tick (o_enb) that drives the counter's i_enb.
- Consumes the counter's overflow flag and counts laps (overflow events).
- Stops ticking after MAX_LAPS laps.
- Top-level glue between board buttons and the counter/display path.

Parameters:
- PRESCALE, default 4: clk cycles per o_enb tick; must be ≥2.
- MAX_LAPS, default 10: overflow events after which the block enters DONE; range 1..2**LAP_W-1.
- LAP_W, default 4: width of the lap counter.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-low reset (0 = reset asserted).
- i_start, input, 1: start/resume button level, synchronous to clk.
- i_stop, input, 1: pause button level, synchronous to clk.
- i_clear, input, 1: clear button level, synchronous to clk.
- i_ovf, input, 1: overflow flag from the downstream counter; a level that stays high for a whole tick period.
- o_enb, output, 1: one-cycle enable tick to the downstream counter.
- o_clr, output, 1: one-cycle synchronous clear pulse for downstream counter/display logic.
- o_laps, output, LAP_W: number of overflow events counted since the last clear.
- o_done, output, 1: high while in DONE.
- o_state, output, 2: current state (IDLE=0, RUN=1, PAUSE=2, DONE=3).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; prescaler=0; o_laps=0.
  - o_enb=0, o_clr=0, o_done=0.
  - Edge-detect history regs for start/stop/clear are set to 1, so a button held through reset release gives no edge.
  - The i_ovf history reg is set to 0.
- Edges: each input is registered once. The edge is `cur & ~prev`, evaluated in the same cycle; only rising edges act.
- Priority within a cycle: clear > stop > start.
- Clear edge, any state:
  - next state IDLE; prescaler=0; o_laps=0; o_enb=0.
  - o_clr=1 for exactly the following cycle.
  - A lap edge in the same cycle is discarded.
- IDLE: start edge -> RUN with prescaler=0. Stop edges are ignored.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler==PRESCALE-1 it wraps to 0 and o_enb<=1. o_enb is registered, so it is high in the next cycle only.
  - The first tick is high in the cycle after the PRESCALE-th clk edge following RUN entry. Ticks then repeat every PRESCALE cycles.
- RUN, stop edge: -> PAUSE. Prescaler holds its value; o_enb<=0, suppressing any tick due that cycle.
- RUN, start edge: ignored.
- PAUSE:
  - Prescaler and o_laps hold; o_enb=0.
  - Start edge -> RUN; the prescaler resumes from the held value, with no restart.
  - Start and stop edges in the same cycle: stop wins, so the block stays in PAUSE.
- Lap counting: a rising edge of i_ovf in RUN or PAUSE increments o_laps. Edges in IDLE and DONE are ignored.
  - If o_laps==MAX_LAPS-1 at the increment: o_laps<=MAX_LAPS and state<=DONE on the same edge.
  - o_enb<=0 from that edge onward.
- Simultaneous stop edge and final lap edge: DONE wins.
- DONE: o_done=1, o_enb=0, o_laps holds at MAX_LAPS. Only a clear edge leaves DONE; start and stop are ignored.
- Width rules:
  - Prescaler width is $clog2(PRESCALE).
  - o_laps never wraps; the DONE transition guarantees o_laps ≤ MAX_LAPS.
- Reset mid-operation: immediate return to the reset values above. No o_clr pulse is generated by reset.

Decomposition:
- Package cntr_ctrl_pkg holds:
  - state enum `ctrl_state_e` (IDLE, RUN, PAUSE, DONE; 2-bit encoding fixed as above);
  - default PRESCALE, MAX_LAPS and LAP_W localparams;
  - a struct bundling prescaler, laps and state for the registered datapath.
- Sub-module rise_edge_det:
  - parameter RST_VAL for the history reg;
  - ports clk, rst, i_lvl, o_edge;
  - instantiated 4× (start, stop, clear, ovf).
- FSM, prescaler and lap counter stay in cntr_run_ctrl.

Test Plan:
All scenarios use PRESCALE=4, MAX_LAPS=3, with the block driving a MAXCNT=8 counter.
1. Reset with i_start held high, release rst -> no transition; state=IDLE, o_enb=0, o_laps=0.
2. Pulse i_start -> state=RUN next cycle; first o_enb high 4 cycles after RUN entry, then every 4 cycles; exactly one cycle wide each time.
3. Stop pulse while RUN with prescaler=2 -> PAUSE, no o_enb. Start pulse 10 cycles later -> next o_enb 2 cycles after resume.
4. Run freely -> downstream ovf every 9 ticks (36 cycles); o_laps steps 1,2,3. On the third edge: state=DONE, o_done=1, o_enb stays 0 for 50+ cycles.
5. Clear pulse in DONE -> one-cycle o_clr, state=IDLE, o_laps=0, o_done=0.
6. Start and stop pulsed in the same cycle from PAUSE -> stays PAUSE. Clear and start together from IDLE -> o_clr pulses, state stays IDLE. Assert rst mid-RUN -> all outputs 0 asynchronously.
